// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter.
// Holds the FSM state encoding and the default ALU select width.
package alu_arbiter_pkg;

    localparam int SEL_W_DEF = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way grant logic: a lone requester always wins,
// otherwise the priority pointer picks the winner.
module rr_arb2
    import alu_arbiter_pkg::*;
(
    input  logic       valid0,
    input  logic       valid1,
    input  logic       ptr,
    output logic [1:0] grant
);

    // One-hot grant; zero when nobody is asking
    always_comb begin
        grant = 2'b00;
        if (valid0 && valid1) begin
            grant = ptr ? 2'b10 : 2'b01;
        end else if (valid0) begin
            grant = 2'b01;
        end else if (valid1) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters.
// Accept -> drive ALU -> hold result until the owner consumes it.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SEL_W = SEL_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [SEL_W-1:0] req0_sel,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [SEL_W-1:0] req1_sel,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic [SEL_W-1:0] alu_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero
);

    state_t     state;
    state_t     state_nx;
    logic       ptr;
    logic       owner;
    logic [1:0] grant;
    logic       accept;
    logic       done;

    rr_arb2 u_arb (
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .ptr    (ptr),
        .grant  (grant)
    );

    // Next-state and handshake outputs; reset masks the ready lines
    always_comb begin
        state_nx   = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        accept     = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                req0_ready = grant[0] && !reset;
                req1_ready = grant[1] && !reset;
                accept     = (|grant) && !reset;
                if (accept) begin
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                state_nx = RESP;
            end
            RESP: begin
                rsp0_valid = !owner;
                rsp1_valid = owner;
                done       = owner ? rsp1_ready : rsp0_ready;
                if (done) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Operand capture, result capture and fairness pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr        <= 1'b0;
            owner      <= 1'b0;
            alu_sel    <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
        end else begin
            if (accept) begin
                owner   <= grant[1];
                alu_sel <= grant[1] ? req1_sel : req0_sel;
                alu_a   <= grant[1] ? req1_a : req0_a;
                alu_b   <= grant[1] ? req1_b : req0_b;
            end
            if (state == ISSUE) begin
                rsp_result <= alu_result;
                rsp_zero   <= alu_zero;
            end
            if (done) begin
                ptr <= ~owner;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed and random transactions
// compared against a transaction-level reference model.
module tb_alu_arbiter;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic [2:0]    req0_sel, req1_sel;
    logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
    logic          rsp0_valid, rsp1_valid;
    logic          rsp0_ready, rsp1_ready;
    logic [W-1:0]  rsp_result;
    logic          rsp_zero;
    logic [2:0]    alu_sel;
    logic [W-1:0]  alu_a, alu_b;
    logic [W-1:0]  alu_result;
    logic          alu_zero;

    int vectors = 0;
    int errors  = 0;
    bit m_ptr   = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [W-1:0] alu_ref(
        input logic [2:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
        case (s)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a + b;
            3'd3: return a ^ b;
            3'd4: return a << b[4:0];
            3'd5: return a >> b[4:0];
            3'd6: return a - b;
            default: return {31'b0, a < b};
        endcase
    endfunction

    assign alu_result = alu_ref(alu_sel, alu_a, alu_b);
    assign alu_zero   = (alu_result == '0);

    alu_arbiter #(.WIDTH(W), .SEL_W(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_sel   (req0_sel),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_sel   (req1_sel),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .alu_sel    (alu_sel),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .alu_zero   (alu_zero)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".req0_ready"}, req0_ready, 0);
        chk({tag, ".req1_ready"}, req1_ready, 0);
        chk({tag, ".rsp0_valid"}, rsp0_valid, 0);
        chk({tag, ".rsp1_valid"}, rsp1_valid, 0);
        chk({tag, ".rsp_result"}, rsp_result, 0);
        chk({tag, ".rsp_zero"}, rsp_zero, 0);
        chk({tag, ".alu_sel"}, alu_sel, 0);
        chk({tag, ".alu_a"}, alu_a, 0);
        chk({tag, ".alu_b"}, alu_b, 0);
    endtask

    task automatic clear_inputs();
        req0_valid = 0; req1_valid = 0;
        rsp0_ready = 0; rsp1_ready = 0;
        req0_sel = 0; req1_sel = 0;
        req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    endtask

    // Called at posedge+1; one full operation from offer to consume.
    task automatic do_txn(
        input logic v0, input logic [2:0] s0,
        input logic [W-1:0] a0, input logic [W-1:0] b0,
        input logic v1, input logic [2:0] s1,
        input logic [W-1:0] a1, input logic [W-1:0] b1,
        input int hold);
        int g;
        logic [2:0]   ws;
        logic [W-1:0] wa, wb, er;
        req0_valid = v0; req0_sel = s0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_sel = s1; req1_a = a1; req1_b = b1;
        rsp0_ready = 0; rsp1_ready = 0;
        #1;
        if (!v0 && !v1) g = -1;
        else if (v0 && v1) g = int'(m_ptr);
        else g = v0 ? 0 : 1;
        chk("offer.req0_ready", req0_ready, g == 0);
        chk("offer.req1_ready", req1_ready, g == 1);
        if (g < 0) begin
            @(posedge clk); #1;
            return;
        end
        ws = (g == 0) ? s0 : s1;
        wa = (g == 0) ? a0 : a1;
        wb = (g == 0) ? b0 : b1;
        er = alu_ref(ws, wa, wb);
        @(posedge clk); #2;
        chk("issue.req0_ready", req0_ready, 0);
        chk("issue.req1_ready", req1_ready, 0);
        chk("issue.alu_sel", alu_sel, ws);
        chk("issue.alu_a", alu_a, wa);
        chk("issue.alu_b", alu_b, wb);
        chk("issue.rsp_valid", {rsp1_valid, rsp0_valid}, 0);
        @(posedge clk); #2;
        chk("resp.rsp0_valid", rsp0_valid, g == 0);
        chk("resp.rsp1_valid", rsp1_valid, g == 1);
        chk("resp.rsp_result", rsp_result, er);
        chk("resp.rsp_zero", rsp_zero, er == '0);
        for (int i = 0; i < hold; i++) begin
            req0_valid = 1; req1_valid = 1;
            if (g == 0) rsp1_ready = 1; else rsp0_ready = 1;
            @(posedge clk); #2;
            chk("hold.rsp_valid", {rsp1_valid, rsp0_valid},
                (g == 0) ? 2'b01 : 2'b10);
            chk("hold.rsp_result", rsp_result, er);
            chk("hold.req_ready", {req1_ready, req0_ready}, 0);
        end
        rsp0_ready = (g == 0); rsp1_ready = (g == 1);
        @(posedge clk); #1;
        rsp0_ready = 0; rsp1_ready = 0;
        req0_valid = 0; req1_valid = 0;
        m_ptr = (g == 0);
        #1;
        chk("idle.rsp_valid", {rsp1_valid, rsp0_valid}, 0);
        chk("idle.alu_sel_held", alu_sel, ws);
        chk("idle.alu_a_held", alu_a, wa);
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        req0_valid = 1; req1_valid = 1;
        #1;
        chk_all_zero("reset");
        req0_valid = 0; req1_valid = 0;
        reset = 0;
        m_ptr = 0;
        @(posedge clk); #1;

        // Single requester add, then subtract to zero
        do_txn(1, 3'b010, 5, 7, 0, 0, 0, 0, 0);
        chk("add.result", rsp_result, 12);
        do_txn(1, 3'd6, 9, 9, 0, 0, 0, 0, 0);
        chk("sub.zero", rsp_zero, 1);

        // Lone req1 wins despite pointer
        do_txn(0, 0, 0, 0, 1, 3'd1, 32'hf0, 32'h0f, 0);

        // Long hold with non-owner ready pulsed
        do_txn(0, 0, 0, 0, 1, 3'd2, 100, 23, 5);
        do_txn(1, 3'd3, 32'haa55, 32'hffff, 1, 3'd0, 3, 1, 2);

        // Reset mid-flight in ISSUE drops the operation
        req0_valid = 1; req0_sel = 3'd2; req0_a = 1; req0_b = 2;
        @(posedge clk); #1;
        req0_valid = 0;
        reset = 1;
        @(posedge clk); #2;
        chk_all_zero("rst_issue");
        reset = 0;
        m_ptr = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            chk("post_rst.rsp_valid", {rsp1_valid, rsp0_valid}, 0);
        end
        @(posedge clk); #1;

        // Contention after reset: 0,1,0,1
        for (int i = 0; i < 4; i++) begin
            do_txn(1, 3'd2, i, 1, 1, 3'd6, 10, i, 0);
            chk("alt.owner_ptr", m_ptr, (i % 2 == 0));
        end

        // Random traffic
        for (int i = 0; i < 25; i++) begin
            do_txn($urandom_range(0, 1), 3'($urandom_range(0, 7)),
                   $urandom, 32'($urandom_range(0, 40)),
                   $urandom_range(0, 1), 3'($urandom_range(0, 7)),
                   $urandom, 32'($urandom_range(0, 40)),
                   $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits.
REQ-002 Parameter SEL_W, default 3: ALU select width, matching the 3-bit ALU select bus.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 reqN_valid  input  1  requester N (N=0,1) presents an operation.
REQ-006 reqN_ready  output  1  arbiter accepts requester N's operation this cycle.
REQ-007 reqN_sel  input  SEL_W  requested ALU select code for requester N.
REQ-008 reqN_a, reqN_b  input  WIDTH  operands for requester N.
REQ-009 rspN_valid  output  1  result for requester N is available.
REQ-010 rspN_ready  input  1  requester N consumes the result.
REQ-011 rsp_result  output  WIDTH  captured ALU result, shared by both response ports.
REQ-012 rsp_zero  output  1  captured ALU zero flag.
REQ-013 alu_sel  output  SEL_W  select bus to the shared combinational ALU.
REQ-014 alu_a, alu_b  output  WIDTH  operands to the shared ALU.
REQ-015 alu_result  input  WIDTH  combinational ALU result.
REQ-016 alu_zero  input  1  combinational ALU zero flag.

Function
REQ-017 The FSM SHALL have three states: IDLE, ISSUE, RESP.
REQ-018 In IDLE, reqN_ready SHALL be high only for the granted requester, and only when that requester's reqN_valid is high.
REQ-019 With one valid requester in IDLE, that requester SHALL be granted regardless of the priority pointer.
REQ-020 With both valid in IDLE, the requester named by the 1-bit priority pointer SHALL be granted.
REQ-021 On reqN_valid && reqN_ready, the sel and operands SHALL be registered into alu_sel/alu_a/alu_b, the grant owner recorded, and the FSM SHALL move to ISSUE.
REQ-022 In ISSUE, both reqN_ready SHALL be low; alu_result and alu_zero SHALL be registered into rsp_result and rsp_zero at the end of the cycle; the FSM SHALL move to RESP.
REQ-023 In RESP, rspN_valid SHALL be high only for the owner; rsp_result and rsp_zero SHALL stay stable until rspN_ready is sampled high.
REQ-024 On owner rspN_valid && rspN_ready, the FSM SHALL return to IDLE and the priority pointer SHALL point to the non-owner.
REQ-025 Latency: acceptance in cycle T gives ALU drive in T+1 and rspN_valid in T+2; with rspN_ready held high, the next acceptance is possible in cycle T+3.
REQ-026 alu_sel/alu_a/alu_b SHALL hold their last registered values outside ISSUE.
REQ-027 rspN_ready asserted by a non-owner, or asserted outside RESP, SHALL be ignored.
REQ-028 reqN_sel values SHALL be passed to the ALU unmodified, with no decode or range check.
REQ-029 No operation SHALL be lost or duplicated: each accepted request yields exactly one response handshake.

Reset
REQ-030 While reset is high at a clock edge, the FSM SHALL enter IDLE, the pointer SHALL be 0, and all outputs, including alu_* and rsp_*, SHALL be 0.
REQ-031 Reset asserted in ISSUE or RESP SHALL drop the in-flight operation with no response.
REQ-032 After reset, the first grant SHALL follow REQ-019/REQ-020 with the pointer at 0.

Structure
REQ-033 The state encoding (IDLE=2'd0, ISSUE=2'd1, RESP=2'd2) and the SEL_W default SHALL live in the shared package used by the datapath's ALU control.
REQ-034 The grant logic SHALL be one sub-module, rr_arb2 (inputs valid0, valid1, ptr; output one-hot grant); everything else stays in alu_arbiter.

Verification
REQ-035 Only req0 valid, sel=3'b010, a=5, b=7, ALU model adds -> req0_ready high in cycle T, rsp0_valid in T+2, rsp_result=12, rsp_zero=0.
REQ-036 Both valid after reset -> req0 granted first; with both still valid, req1 granted next; grants strictly alternate 0,1,0,1.
REQ-037 rsp1_ready held low 5 cycles -> rsp1_valid and rsp_result stable for all 5 cycles; both reqN_ready low throughout.
REQ-038 ALU result 0 (a=9, b=9, subtract) -> rsp_zero=1.
REQ-039 Reset pulsed in ISSUE -> no rspN_valid afterwards, all outputs 0, next grant to req0.
REQ-040 rsp0_ready pulsed while req1 owns RESP -> ignored; FSM stays in RESP until rsp1_ready.
